// File: rtl/alsaqr_rst_sequencer_if.sv
// Reset-sequencer signal bundle: board/JTAG/lock inputs
// toward the sequencer, SoC reset and status back out.
interface alsaqr_rst_sequencer_if;
  logic       pad_reset;
  logic       jtag_trst_n;
  logic       locked;
  logic       rst_n;
  logic [1:0] state;
  logic [7:0] reset_count;

  modport master (
    output pad_reset,
    output jtag_trst_n,
    output locked,
    input  rst_n,
    input  state,
    input  reset_count
  );

  modport slave (
    input  pad_reset,
    input  jtag_trst_n,
    input  locked,
    output rst_n,
    output state,
    output reset_count
  );
endinterface

// File: rtl/alsaqr_rst_sequencer.sv
// SoC reset sequencer: synchronises board/JTAG/lock inputs,
// debounces the reset request and holds reset after lock.
module alsaqr_rst_sequencer_core #(
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 16,
  parameter int HoldCycles     = 64
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  alsaqr_rst_sequencer_if.slave bus
);
  localparam int DbW   = $clog2(DebounceCycles + 1);
  localparam int HoldW = $clog2(HoldCycles + 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  logic [SyncStages-1:0] pad_q, trst_q, lock_q;
  logic pad_s, trst_s, lock_s, req_s;
  logic req_db_q, req_db_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic rst_q, abort;
  state_e state_q, state_d;

  assign pad_s  = pad_q[SyncStages-1];
  assign trst_s = trst_q[SyncStages-1];
  assign lock_s = lock_q[SyncStages-1];
  assign req_s  = pad_s | ~trst_s;
  assign abort  = req_db_q | ~lock_s;

  always_comb begin
    req_db_d = req_db_q;
    db_cnt_d = '0;
    if (req_s != req_db_q) begin
      if (db_cnt_q == DbW'(DebounceCycles - 1)) begin
        req_db_d = req_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Abort outranks the HOLD->RUN step so a late loss never releases reset.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (!abort) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q + 1'b1;
        if (abort) begin
          state_d = WAIT_LOCK;
        end else if (hold_cnt_q == HoldW'(HoldCycles - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = WAIT_LOCK;
          if (cnt_q != 8'hff) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pad_q      <= '1;
      trst_q     <= '0;
      lock_q     <= '0;
      req_db_q   <= 1'b1;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      cnt_q      <= '0;
      state_q    <= WAIT_LOCK;
      rst_q      <= 1'b0;
    end else begin
      pad_q      <= {pad_q[SyncStages-2:0], bus.pad_reset};
      trst_q     <= {trst_q[SyncStages-2:0], bus.jtag_trst_n};
      lock_q     <= {lock_q[SyncStages-2:0], bus.locked};
      req_db_q   <= req_db_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      rst_q      <= (state_d == RUN);
    end
  end

  assign bus.rst_n       = rst_q;
  assign bus.state       = state_q;
  assign bus.reset_count = cnt_q;
endmodule

module alsaqr_rst_sequencer #(
  parameter int SyncStages     = 2,
  parameter int DebounceCycles = 16,
  parameter int HoldCycles     = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pad_reset_i,
  input  logic       jtag_trst_ni,
  input  logic       locked_i,
  output logic       rst_no,
  output logic [1:0] state_o,
  output logic [7:0] reset_count_o
);
  alsaqr_rst_sequencer_if bus ();

  assign bus.pad_reset   = pad_reset_i;
  assign bus.jtag_trst_n = jtag_trst_ni;
  assign bus.locked      = locked_i;
  assign rst_no          = bus.rst_n;
  assign state_o         = bus.state;
  assign reset_count_o   = bus.reset_count;

  alsaqr_rst_sequencer_core #(
    .SyncStages    (SyncStages),
    .DebounceCycles(DebounceCycles),
    .HoldCycles    (HoldCycles)
  ) i_core (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .bus  (bus)
  );
endmodule

// File: tb/tb_alsaqr_rst_sequencer.sv
// Bench for alsaqr_rst_sequencer: streak-based reference model
// feeding a scoreboard, plus directed timing scenarios.
module tb_alsaqr_rst_sequencer;
  localparam int SS = 2;
  localparam int DB = 16;
  localparam int HC = 64;

  typedef struct packed {
    logic       rn;
    logic [1:0] st;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic srst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  alsaqr_rst_sequencer_if tb_if ();

  alsaqr_rst_sequencer #(
    .SyncStages    (SS),
    .DebounceCycles(DB),
    .HoldCycles    (HC)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (srst_n),
    .pad_reset_i  (tb_if.pad_reset),
    .jtag_trst_ni (tb_if.jtag_trst_n),
    .locked_i     (tb_if.locked),
    .rst_no       (tb_if.rst_n),
    .state_o      (tb_if.state),
    .reset_count_o(tb_if.reset_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: inputs pass through SS-deep delay lines; req_db
  // flips once the last DB req samples all oppose it; reset
  // is released once lock & ~req_db held for HC+1 edges.
  exp_t exp_q[$];
  bit   m_init = 0;
  bit   pad_l[$], trst_l[$], lock_l[$], win[$];
  bit   m_db;
  int   streak, m_cnt;

  task automatic model_step();
    bit rs, ok, run_prev, all_diff;
    exp_t e;
    if (!srst_n) begin
      pad_l = {}; trst_l = {}; lock_l = {};
      for (int i = 0; i < SS; i++) begin
        pad_l.push_back(1'b1);
        trst_l.push_back(1'b0);
        lock_l.push_back(1'b0);
      end
      m_db = 1'b1; win = {};
      streak = 0; m_cnt = 0; m_init = 1'b1;
    end else if (m_init) begin
      rs = pad_l[0] | ~trst_l[0];
      ok = lock_l[0] & ~m_db;
      run_prev = streak > HC;
      win.push_back(rs);
      if (win.size() > DB) void'(win.pop_front());
      if (win.size() == DB) begin
        all_diff = 1'b1;
        foreach (win[i]) if (win[i] == m_db) all_diff = 1'b0;
        if (all_diff) m_db = ~m_db;
      end
      if (!ok) streak = 0;
      else if (streak <= HC) streak++;
      if (run_prev && !ok && m_cnt < 255) m_cnt++;
      void'(pad_l.pop_front());
      void'(trst_l.pop_front());
      void'(lock_l.pop_front());
      pad_l.push_back(tb_if.pad_reset);
      trst_l.push_back(tb_if.jtag_trst_n);
      lock_l.push_back(tb_if.locked);
    end
    if (m_init) begin
      e.rn  = streak > HC;
      e.st  = (streak == 0) ? 2'd0 : (streak > HC) ? 2'd2 : 2'd1;
      e.cnt = 8'(m_cnt);
      exp_q.push_back(e);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_rst_no", tb_if.rst_n, e.rn);
        chk("sb_state", tb_if.state, e.st);
        chk("sb_count", tb_if.reset_count, e.cnt);
      end
    end
  end

  task automatic wait_rst(input logic v, input int max,
                          output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (tb_if.rst_n !== v && n < max);
  endtask

  task automatic wait_st(input logic [1:0] v, input int max,
                         output int n, output bit seen_run);
    n = 0; seen_run = 0;
    do begin
      @(posedge clk); #1; n++;
      if (tb_if.state == 2'd2) seen_run = 1;
    end while (tb_if.state !== v && n < max);
  endtask

  initial begin : stim
    int n, c;
    bit seen;
    srst_n = 1'b0;
    tb_if.pad_reset = 1'b0;
    tb_if.jtag_trst_n = 1'b1;
    tb_if.locked = 1'b1;
    repeat (4) @(negedge clk);
    srst_n = 1'b1;
    wait_rst(1'b1, 300, n);
    chk("powerup_edges", n, SS + DB + HC + 1);
    chk("powerup_count", tb_if.reset_count, 0);

    @(negedge clk) tb_if.pad_reset = 1'b1;
    repeat (10) @(negedge clk);
    tb_if.pad_reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("glitch_rst_no", tb_if.rst_n, 1);
    chk("glitch_count", tb_if.reset_count, 0);

    @(negedge clk) tb_if.pad_reset = 1'b1;
    wait_rst(1'b0, 100, n);
    chk("press_fall", n, 19);
    repeat (22) @(negedge clk);
    tb_if.pad_reset = 1'b0;
    wait_rst(1'b1, 300, n);
    chk("press_rise", n, 83);
    chk("press_count", tb_if.reset_count, 1);

    @(negedge clk) tb_if.jtag_trst_n = 1'b0;
    wait_rst(1'b0, 100, n);
    chk("trst_fall", n, 19);
    repeat (2) @(negedge clk);
    tb_if.jtag_trst_n = 1'b1;
    wait_rst(1'b1, 300, n);
    chk("trst_rise", n, 83);
    chk("trst_count", tb_if.reset_count, 2);

    @(negedge clk) tb_if.locked = 1'b0;
    wait_rst(1'b0, 20, n);
    chk("lockloss_fall", n, SS + 1);
    @(negedge clk) tb_if.locked = 1'b1;
    wait_st(2'd1, 20, n, seen);
    chk("hold_entry", n, SS + 1);
    repeat (30) @(negedge clk);
    tb_if.locked = 1'b0;
    wait_st(2'd0, 20, n, seen);
    chk("hold_abort_edges", n, SS + 1);
    chk("hold_abort_norun", seen, 0);
    @(negedge clk) tb_if.locked = 1'b1;
    wait_rst(1'b1, 200, n);
    chk("hold_restart", n, SS + HC + 1);

    // Request debounced 16 cycles ahead so both hit one edge.
    c = tb_if.reset_count;
    @(negedge clk) tb_if.pad_reset = 1'b1;
    repeat (16) @(negedge clk);
    tb_if.locked = 1'b0;
    wait_rst(1'b0, 20, n);
    chk("simul_fall", n, 3);
    repeat (3) @(negedge clk);
    chk("simul_count", tb_if.reset_count, c + 1);
    tb_if.pad_reset = 1'b0;
    tb_if.locked = 1'b1;
    wait_rst(1'b1, 300, n);
    chk("simul_rise", n, 83);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      tb_if.pad_reset   = ($urandom_range(0, 3) == 0);
      tb_if.jtag_trst_n = ($urandom_range(0, 3) != 0);
      tb_if.locked      = ($urandom_range(0, 4) != 0);
      repeat ($urandom_range(1, 90)) @(negedge clk);
    end
    tb_if.pad_reset = 1'b0;
    tb_if.jtag_trst_n = 1'b1;
    tb_if.locked = 1'b1;
    wait_rst(1'b1, 400, n);
    chk("random_recover", int'(n < 400), 1);

    for (int i = 0; i < 300; i++) begin
      @(negedge clk) tb_if.locked = 1'b0;
      wait_rst(1'b0, 20, n);
      @(negedge clk) tb_if.locked = 1'b1;
      wait_rst(1'b1, 200, n);
      chk("sat_rise", n, SS + HC + 1);
    end
    chk("sat_count", tb_if.reset_count, 255);

    @(negedge clk) srst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrun_rst_no", tb_if.rst_n, 0);
    chk("midrun_state", tb_if.state, 0);
    chk("midrun_count", tb_if.reset_count, 0);
    @(negedge clk) srst_n = 1'b1;
    repeat (10) @(negedge clk);
    srst_n = 1'b0;
    @(negedge clk) srst_n = 1'b1;
    wait_rst(1'b1, 300, n);
    chk("middb_restart", n, 83);

    @(negedge clk) tb_if.locked = 1'b0;
    wait_rst(1'b0, 20, n);
    @(negedge clk) tb_if.locked = 1'b1;
    wait_st(2'd1, 20, n, seen);
    repeat (20) @(negedge clk);
    srst_n = 1'b0;
    @(negedge clk) srst_n = 1'b1;
    wait_rst(1'b1, 300, n);
    chk("midhold_restart", n, 83);
    chk("midhold_count", tb_if.reset_count, 0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alsaqr_rst_sequencer.md
ALSAQR_RST_SEQUENCER -- requirements
Module: alsaqr_rst_sequencer

Interface
REQ-001 The block SHALL have a parameter SyncStages, default 2, giving the synchronizer depth for every asynchronous input (minimum 2).
REQ-002 The block SHALL have a parameter DebounceCycles, default 16, giving the consecutive stable cycles needed to accept a change of the reset request (minimum 1).
REQ-003 The block SHALL have a parameter HoldCycles, default 64, giving the cycles the downstream reset stays asserted after lock and release (minimum 1).
REQ-004 The block SHALL have port clk_i, input, 1 bit: single clock (clock-manager output).
REQ-005 The block SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port pad_reset_i, input, 1 bit: asynchronous board reset button, active-high.
REQ-007 The block SHALL have port jtag_trst_ni, input, 1 bit: asynchronous JTAG TRST, active-low.
REQ-008 The block SHALL have port locked_i, input, 1 bit: asynchronous clock-manager lock indication.
REQ-009 The block SHALL have port rst_no, output, 1 bit: active-low SoC reset, driven directly from a flop.
REQ-010 The block SHALL have port state_o, output, 2 bits: FSM state, with WAIT_LOCK=0, HOLD=1, RUN=2.
REQ-011 The block SHALL have port reset_count_o, output, 8 bits: count of RUN exits.

Function
REQ-012 The block SHALL pass pad_reset_i, jtag_trst_ni and locked_i through SyncStages flops each, producing req inputs pad_s, trst_s and lock_s.
REQ-013 The block SHALL form the raw request as req_s = pad_s OR NOT trst_s.
REQ-014 The debouncer SHALL behave as follows on each cycle:
- If req_s differs from req_db, db_cnt increments.
- When db_cnt equals DebounceCycles-1 and req_s still differs, req_db takes req_s and db_cnt clears to 0.
- If req_s equals req_db, db_cnt clears to 0.
REQ-015 The debounce counter width SHALL be $clog2(DebounceCycles+1), and the counter SHALL never wrap.
REQ-016 In WAIT_LOCK, the block SHALL move to HOLD when lock_s=1 and req_db=0, and load hold_cnt with 0; otherwise it SHALL stay in WAIT_LOCK.
REQ-017 In HOLD, the block SHALL increment hold_cnt each cycle and enter RUN on the cycle hold_cnt equals HoldCycles-1.
REQ-018 In HOLD, if req_db=1 or lock_s=0, the block SHALL return to WAIT_LOCK; this abort SHALL take priority over the RUN transition.
REQ-019 In RUN, if req_db=1 or lock_s=0, the block SHALL return to WAIT_LOCK; otherwise it SHALL stay in RUN.
REQ-020 rst_no SHALL be 1 exactly when the state register is RUN, with no combinational path from any input.
REQ-021 The block SHALL increment reset_count_o on each RUN->WAIT_LOCK transition and saturate it at 255.
REQ-022 After rst_ni is released with the inputs already clean, rst_no SHALL rise after exactly SyncStages+DebounceCycles+HoldCycles+1 rising edges (83 with default parameters).
REQ-023 A glitch on req_s shorter than DebounceCycles cycles SHALL have no effect on req_db, state or rst_no.
REQ-024 A loss of lock SHALL NOT be debounced and SHALL deassert rst_no SyncStages+1 edges after the locked_i fall.
REQ-025 When lock loss and a request occur in the same cycle, the block SHALL take a single transition to WAIT_LOCK and increment reset_count_o by 1.

Reset
REQ-026 While rst_ni=0 at a clock edge, the block SHALL set:
- state to WAIT_LOCK and rst_no to 0;
- all synchronizer flops to the asserted-reset values (pad 1, trst 0, lock 0);
- req_db to 1;
- db_cnt, hold_cnt and reset_count_o to 0.
REQ-027 An rst_ni assertion in any state, including mid-HOLD or mid-debounce, SHALL take effect at the next edge and restart the full sequence.

Verification
REQ-028 The bench SHALL cover clean power-up: rst_ni low for 4 cycles, then high; pad_reset_i=0, jtag_trst_ni=1, locked_i=1 -> rst_no rises at edge 83, state_o 0->1->2, reset_count_o=0.
REQ-029 The bench SHALL cover a button glitch in RUN: pad_reset_i high for 10 cycles -> rst_no stays 1 and reset_count_o stays 0.
REQ-030 The bench SHALL cover a button press in RUN: pad_reset_i high for 40 cycles -> rst_no falls 19 edges after the rise, rst_no rises again 83 edges after the release, reset_count_o=1.
REQ-031 The bench SHALL cover lock loss during HOLD: locked_i falls at HOLD cycle 30 -> state_o returns to 0 without reaching RUN, and the HOLD count restarts from 0 once lock returns.
REQ-032 The bench SHALL cover JTAG TRST: jtag_trst_ni low for 20 cycles in RUN -> same behaviour as the button press.
REQ-033 The bench SHALL cover counter saturation and mid-operation reset: 300 lock-loss events -> reset_count_o=255; rst_ni pulsed low during RUN -> all outputs return to reset values at the next edge.
